// File: rtl/spram_pixel_packer_pkg.sv
// Shared widths, write masks and state encodings for the pixel packer.
package spram_pixel_packer_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 10;

  localparam logic [3:0]        MASK_FULL = 4'b1111;
  localparam logic [3:0]        MASK_LOW  = 4'b0011;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/spram_pixel_packer_edge_detect.sv
// Rising-edge detector: compares a level input with its value one clock earlier.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= sig;
  end

  assign rise = sig & ~prev;

endmodule

// File: rtl/spram_pixel_packer.sv
// Crops a pixel stream to a window and packs pixel pairs into 16-bit SPRAM
// words, flushing half words at line end and flagging address exhaustion.
module spram_pixel_packer
  import spram_pixel_packer_pkg::*;
#(
  parameter int X_START = 0,
  parameter int Y_START = 0,
  parameter int WIDTH   = 64,
  parameter int HEIGHT  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_valid,
  input  logic [7:0]        pixel_data,
  input  logic              hsync,
  input  logic              vsync,
  output logic              wen,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [3:0]        wr_mask,
  output logic              frame_done,
  output logic              overflow
);

  logic hs_rise;
  logic vs_rise;

  edge_detect u_hs_edge (.clk(clk), .reset(reset), .sig(hsync), .rise(hs_rise));
  edge_detect u_vs_edge (.clk(clk), .reset(reset), .sig(vsync), .rise(vs_rise));

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  x_q, y_q;
  logic [ADDR_W-1:0] addr_q;
  logic              addr_full_q;
  logic              pend_q, pend_d;
  logic [7:0]        pend_data_q, pend_data_d;
  logic              frame_done_d;

  logic              accept;
  logic              write_req;
  logic [DATA_W-1:0] write_data;
  logic [3:0]        write_mask;

  // NOTE: always_comb assigns every output a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    if (vs_rise) begin
      state_d      = ACTIVE;
      frame_done_d = (state_q == ACTIVE);
    end
  end

  // A vsync rise restarts the frame, so a pixel in that cycle is not taken.
  assign accept = (state_q == ACTIVE) && pixel_valid && !vs_rise
               && (int'(x_q) >= X_START) && (int'(x_q) < X_START + WIDTH)
               && (int'(y_q) >= Y_START) && (int'(y_q) < Y_START + HEIGHT);

  always_comb begin
    write_req   = 1'b0;
    write_data  = '0;
    write_mask  = '0;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;

    if (accept) begin
      if (pend_q) begin
        write_req  = 1'b1;
        write_data = {pixel_data, pend_data_q};
        write_mask = MASK_FULL;
        pend_d     = 1'b0;
      end else begin
        pend_d      = 1'b1;
        pend_data_d = pixel_data;
      end
    end

    // Line end flushes whatever is still half filled, including this cycle's pixel.
    if (hs_rise && !vs_rise && pend_d) begin
      write_req  = 1'b1;
      write_data = {8'h00, pend_data_d};
      write_mask = MASK_LOW;
      pend_d     = 1'b0;
    end

    if (vs_rise) pend_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      addr_full_q <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      wen         <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      wr_mask     <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_done  <= frame_done_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      wen         <= 1'b0;

      if (vs_rise || hs_rise)                x_q <= '0;
      else if (pixel_valid && x_q != CNT_MAX) x_q <= x_q + 1'b1;

      if (vs_rise)                        y_q <= '0;
      else if (hs_rise && y_q != CNT_MAX) y_q <= y_q + 1'b1;

      if (vs_rise) begin
        addr_q      <= '0;
        addr_full_q <= 1'b0;
        overflow    <= 1'b0;
      end else if (write_req) begin
        if (addr_full_q) begin
          overflow <= 1'b1;
        end else begin
          wen     <= 1'b1;
          wr_addr <= addr_q;
          wr_data <= write_data;
          wr_mask <= write_mask;
          // The last address is issued once; the counter parks instead of wrapping.
          if (addr_q == ADDR_MAX) addr_full_q <= 1'b1;
          else                    addr_q      <= addr_q + 1'b1;
        end
      end
    end
  end

endmodule
